// File: rtl/fpadd_sched_pkg.sv
// Shared types and constants for the FP add issue scheduler.
// Tracker tags are stored at TAG_MAX_W bits; the top level must use TAGW <= TAG_MAX_W.
package fpadd_sched_pkg;

  localparam int unsigned LANE_W    = 32;
  localparam int unsigned TAG_MAX_W = 8;

  localparam logic MODE_DBL = 1'b1;
  localparam logic MODE_SGL = 1'b0;

  typedef struct packed {
    logic                 vld;
    logic                 mode;
    logic [1:0]           lane_vld;
    logic                 owner0;
    logic                 owner1;
    logic [TAG_MAX_W-1:0] tag0;
    logic [TAG_MAX_W-1:0] tag1;
  } trk_entry_t;

endpackage

// File: rtl/fpadd_sched_track.sv
// In-flight op tracker: a LAT-deep shift register that mirrors the datapath pipeline.
module fpadd_sched_track
  import fpadd_sched_pkg::*;
#(
  parameter int unsigned LAT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  trk_entry_t i_entry,
  output trk_entry_t o_tail,
  output logic       o_any_vld
);

  trk_entry_t stage_q [LAT];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(LAT); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= i_entry;
      for (int i = 1; i < int'(LAT); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign o_tail = stage_q[LAT-1];

  always_comb begin
    o_any_vld = 1'b0;
    for (int i = 0; i < int'(LAT); i++) begin
      o_any_vld = o_any_vld | stage_q[i].vld;
    end
  end

endmodule

// File: rtl/fpadd_issue_sched.sv
// Arbitrates two requesters onto the shared dual-mode FP adder, packing two singles per issue
// when possible, and routes each result back to its owner after the fixed pipeline latency.
module fpadd_issue_sched
  import fpadd_sched_pkg::*;
#(
  parameter int unsigned LAT  = 4,
  parameter int unsigned TAGW = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_hold,
  input  logic            i_r0_valid,
  output logic            o_r0_ready,
  input  logic            i_r0_dbl,
  input  logic [63:0]     i_r0_A,
  input  logic [63:0]     i_r0_B,
  input  logic [TAGW-1:0] i_r0_tag,
  input  logic            i_r1_valid,
  output logic            o_r1_ready,
  input  logic            i_r1_dbl,
  input  logic [63:0]     i_r1_A,
  input  logic [63:0]     i_r1_B,
  input  logic [TAGW-1:0] i_r1_tag,
  output logic            o_issue,
  output logic            o_mode,
  output logic [63:0]     o_A,
  output logic [63:0]     o_B,
  output logic [1:0]      o_lane_valid,
  input  logic [63:0]     i_res,
  output logic            o_r0_rsp_valid,
  output logic [63:0]     o_r0_rsp_data,
  output logic [TAGW-1:0] o_r0_rsp_tag,
  output logic            o_r1_rsp_valid,
  output logic [63:0]     o_r1_rsp_data,
  output logic [TAGW-1:0] o_r1_rsp_tag,
  output logic            o_busy
);

  localparam int unsigned PadW = 64 - LANE_W;

  logic            rr_q, rr_d;
  logic            pack, gnt0, gnt1;
  logic            sel_dbl;
  logic [63:0]     sel_a, sel_b;
  logic [TAGW-1:0] sel_tag;
  trk_entry_t      iss_q, iss_d;
  logic [63:0]     a_q, a_d, b_q, b_d;
  trk_entry_t      tail;
  logic            trk_any;
  logic [63:0]     res_lo, res_hi;

  // Packing two singles beats round-robin; rr only moves on a lone grant.
  always_comb begin
    pack = 1'b0;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    rr_d = rr_q;
    if (!i_hold && !i_rst) begin
      if (i_r0_valid && i_r1_valid && !i_r0_dbl && !i_r1_dbl) begin
        pack = 1'b1;
        gnt0 = 1'b1;
        gnt1 = 1'b1;
      end else if (!rr_q && i_r0_valid) begin
        gnt0 = 1'b1;
      end else if (rr_q && i_r1_valid) begin
        gnt1 = 1'b1;
      end else if (i_r0_valid) begin
        gnt0 = 1'b1;
      end else if (i_r1_valid) begin
        gnt1 = 1'b1;
      end
    end
    if (!pack && gnt0) begin
      rr_d = 1'b1;
    end else if (!pack && gnt1) begin
      rr_d = 1'b0;
    end
  end

  assign o_r0_ready = gnt0;
  assign o_r1_ready = gnt1;

  always_comb begin
    sel_dbl = gnt1 ? i_r1_dbl : i_r0_dbl;
    sel_a   = gnt1 ? i_r1_A   : i_r0_A;
    sel_b   = gnt1 ? i_r1_B   : i_r0_B;
    sel_tag = gnt1 ? i_r1_tag : i_r0_tag;
    iss_d   = '0;
    a_d     = '0;
    b_d     = '0;
    if (pack) begin
      iss_d.vld      = 1'b1;
      iss_d.mode     = MODE_SGL;
      iss_d.lane_vld = 2'b11;
      iss_d.owner0   = 1'b0;
      iss_d.owner1   = 1'b1;
      iss_d.tag0     = TAG_MAX_W'(i_r0_tag);
      iss_d.tag1     = TAG_MAX_W'(i_r1_tag);
      a_d            = {i_r1_A[LANE_W-1:0], i_r0_A[LANE_W-1:0]};
      b_d            = {i_r1_B[LANE_W-1:0], i_r0_B[LANE_W-1:0]};
    end else if (gnt0 || gnt1) begin
      iss_d.vld    = 1'b1;
      iss_d.owner0 = gnt1;
      iss_d.tag0   = TAG_MAX_W'(sel_tag);
      if (sel_dbl) begin
        iss_d.mode     = MODE_DBL;
        iss_d.lane_vld = 2'b11;
        a_d            = sel_a;
        b_d            = sel_b;
      end else begin
        iss_d.mode     = MODE_SGL;
        iss_d.lane_vld = 2'b01;
        a_d            = {{PadW{1'b0}}, sel_a[LANE_W-1:0]};
        b_d            = {{PadW{1'b0}}, sel_b[LANE_W-1:0]};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_q  <= 1'b0;
      iss_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      rr_q  <= rr_d;
      iss_q <= iss_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  assign o_issue      = iss_q.vld;
  assign o_mode       = iss_q.mode;
  assign o_lane_valid = iss_q.lane_vld;
  assign o_A          = a_q;
  assign o_B          = b_q;

  // The issue register feeds the tracker, so the tail lines up with i_res LAT cycles later.
  fpadd_sched_track #(
    .LAT(LAT)
  ) u_track (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_entry  (iss_q),
    .o_tail   (tail),
    .o_any_vld(trk_any)
  );

  assign o_busy = iss_q.vld | trk_any;
  assign res_lo = {{PadW{1'b0}}, i_res[LANE_W-1:0]};
  assign res_hi = {{PadW{1'b0}}, i_res[63:LANE_W]};

  always_comb begin
    o_r0_rsp_valid = 1'b0;
    o_r0_rsp_data  = '0;
    o_r0_rsp_tag   = '0;
    o_r1_rsp_valid = 1'b0;
    o_r1_rsp_data  = '0;
    o_r1_rsp_tag   = '0;
    // Ops still at the tail during reset are dropped too.
    if (tail.vld && !i_rst) begin
      if (tail.lane_vld[0] || tail.mode == MODE_DBL) begin
        if (tail.owner0) begin
          o_r1_rsp_valid = 1'b1;
          o_r1_rsp_data  = (tail.mode == MODE_DBL) ? i_res : res_lo;
          o_r1_rsp_tag   = tail.tag0[TAGW-1:0];
        end else begin
          o_r0_rsp_valid = 1'b1;
          o_r0_rsp_data  = (tail.mode == MODE_DBL) ? i_res : res_lo;
          o_r0_rsp_tag   = tail.tag0[TAGW-1:0];
        end
      end
      if (tail.mode == MODE_SGL && tail.lane_vld[1]) begin
        if (tail.owner1) begin
          o_r1_rsp_valid = 1'b1;
          o_r1_rsp_data  = res_hi;
          o_r1_rsp_tag   = tail.tag1[TAGW-1:0];
        end else begin
          o_r0_rsp_valid = 1'b1;
          o_r0_rsp_data  = res_hi;
          o_r0_rsp_tag   = tail.tag1[TAGW-1:0];
        end
      end
    end
  end

  logic unused_tag_bits;
  assign unused_tag_bits = ^{tail.tag0, tail.tag1};

endmodule

// File: tb/tb_fpadd_issue_sched.sv
// Bench for fpadd_issue_sched: directed scenarios plus random traffic, checked against a
// queue-based reference model and driven by a behavioural FP adder with LAT-cycle latency.
module tb_fpadd_issue_sched;

  localparam int unsigned LAT  = 4;
  localparam int unsigned TAGW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, hold;
  logic [1:0]      rv, rdbl;
  logic [63:0]     ra [2];
  logic [63:0]     rb [2];
  logic [TAGW-1:0] rtag [2];
  logic [TAGW-1:0] tagc [2];
  wire             rdy0, rdy1, o_issue, o_mode, o_busy, rspv0, rspv1;
  wire [63:0]      o_A, o_B, rspd0, rspd1;
  wire [1:0]       o_lane_valid;
  wire [TAGW-1:0]  rspt0, rspt1;
  logic [63:0]     res;

  fpadd_issue_sched #(
    .LAT (LAT),
    .TAGW(TAGW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_hold        (hold),
    .i_r0_valid    (rv[0]),
    .o_r0_ready    (rdy0),
    .i_r0_dbl      (rdbl[0]),
    .i_r0_A        (ra[0]),
    .i_r0_B        (rb[0]),
    .i_r0_tag      (rtag[0]),
    .i_r1_valid    (rv[1]),
    .o_r1_ready    (rdy1),
    .i_r1_dbl      (rdbl[1]),
    .i_r1_A        (ra[1]),
    .i_r1_B        (rb[1]),
    .i_r1_tag      (rtag[1]),
    .o_issue       (o_issue),
    .o_mode        (o_mode),
    .o_A           (o_A),
    .o_B           (o_B),
    .o_lane_valid  (o_lane_valid),
    .i_res         (res),
    .o_r0_rsp_valid(rspv0),
    .o_r0_rsp_data (rspd0),
    .o_r0_rsp_tag  (rspt0),
    .o_r1_rsp_valid(rspv1),
    .o_r1_rsp_data (rspd1),
    .o_r1_rsp_tag  (rspt1),
    .o_busy        (o_busy)
  );

  // Behavioural FP add on normal numbers (singles widened to double, truncated back).
  function automatic real s2r(input logic [31:0] s);
    logic [10:0] e;
    if (s[30:23] == 8'd0) return 0.0;
    e = {3'b000, s[30:23]} + 11'd896;
    return $bitstoreal({s[31], e, s[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd32(input logic [31:0] a, input logic [31:0] b);
    return r2s(s2r(a) + s2r(b));
  endfunction

  function automatic logic [63:0] fadd64(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction

  function automatic logic [63:0] dp_fn(input logic mode, input logic [63:0] a,
                                        input logic [63:0] b);
    if (mode) return fadd64(a, b);
    return {fadd32(a[63:32], b[63:32]), fadd32(a[31:0], b[31:0])};
  endfunction

  logic [63:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= dp_fn(o_mode, o_A, o_B);
    for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign res = pipe[LAT-1];

  typedef struct packed {
    logic        vld;
    logic        mode;
    logic [1:0]  lv;
    logic [63:0] a;
    logic [63:0] b;
  } iss_t;

  typedef struct {
    int              owner;
    logic [63:0]     data;
    logic [TAGW-1:0] tag;
    int              due;
  } rsp_t;

  rsp_t  expq [$];
  int    iss_cycles [$];
  iss_t  ev;
  bit    m_rr;
  logic [1:0] acc;
  int    cyc, total, bad;
  bit    auto_en;
  int    p_req, p_dbl;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int first_of(input int n);
    foreach (expq[i]) if (expq[i].owner == n) return i;
    return -1;
  endfunction

  task automatic push_rsp(input int owner, input logic [63:0] data, input logic [TAGW-1:0] tag);
    rsp_t r;
    r.owner = owner;
    r.data  = data;
    r.tag   = tag;
    r.due   = cyc + 1 + int'(LAT);
    expq.push_back(r);
  endtask

  // Called mid-cycle: compares outputs, then applies this cycle's accepts to the model.
  task automatic model_cycle();
    logic [1:0] g;
    bit         busy_exp;
    int         n;
    if (rst) begin
      expq.delete();
      iss_cycles.delete();
      ev   = '0;
      m_rr = 1'b0;
      acc  = 2'b00;
      return;
    end
    check("issue", o_issue, ev.vld);
    check("mode", o_mode, ev.mode);
    check("lane_valid", o_lane_valid, ev.lv);
    check("opA", o_A, ev.a);
    check("opB", o_B, ev.b);
    while (iss_cycles.size() > 0 && iss_cycles[0] < cyc - int'(LAT)) void'(iss_cycles.pop_front());
    busy_exp = 1'b0;
    foreach (iss_cycles[i]) if (iss_cycles[i] <= cyc) busy_exp = 1'b1;
    check("busy", o_busy, busy_exp);
    for (int k = 0; k < 2; k++) begin
      logic            v;
      logic [63:0]     d;
      logic [TAGW-1:0] t;
      int              idx;
      v   = k ? rspv1 : rspv0;
      d   = k ? rspd1 : rspd0;
      t   = k ? rspt1 : rspt0;
      idx = first_of(k);
      if (v) begin
        if (idx < 0) begin
          check(k ? "rsp1_spurious" : "rsp0_spurious", v, 0);
        end else begin
          check(k ? "rsp1_data" : "rsp0_data", d, expq[idx].data);
          check(k ? "rsp1_tag" : "rsp0_tag", t, expq[idx].tag);
          check(k ? "rsp1_cycle" : "rsp0_cycle", cyc, expq[idx].due);
          expq.delete(idx);
        end
      end else if (idx >= 0 && expq[idx].due <= cyc) begin
        check(k ? "rsp1_missing" : "rsp0_missing", v, 1);
        expq.delete(idx);
      end
    end
    g = 2'b00;
    if (!hold) begin
      if (rv == 2'b11 && rdbl == 2'b00) g = 2'b11;
      else if (rv[m_rr]) g[m_rr] = 1'b1;
      else if (rv[!m_rr]) g[!m_rr] = 1'b1;
    end
    check("ready0", rdy0, g[0]);
    check("ready1", rdy1, g[1]);
    acc = rv & {rdy1, rdy0};
    ev  = '0;
    if (g == 2'b11) begin
      ev.vld = 1'b1;
      ev.lv  = 2'b11;
      ev.a   = {ra[1][31:0], ra[0][31:0]};
      ev.b   = {rb[1][31:0], rb[0][31:0]};
      push_rsp(0, {32'd0, fadd32(ra[0][31:0], rb[0][31:0])}, rtag[0]);
      push_rsp(1, {32'd0, fadd32(ra[1][31:0], rb[1][31:0])}, rtag[1]);
    end else if (g != 2'b00) begin
      n      = int'(g[1]);
      m_rr   = !g[1];
      ev.vld = 1'b1;
      if (rdbl[n]) begin
        ev.mode = 1'b1;
        ev.lv   = 2'b11;
        ev.a    = ra[n];
        ev.b    = rb[n];
        push_rsp(n, fadd64(ra[n], rb[n]), rtag[n]);
      end else begin
        ev.lv = 2'b01;
        ev.a  = {32'd0, ra[n][31:0]};
        ev.b  = {32'd0, rb[n][31:0]};
        push_rsp(n, {32'd0, fadd32(ra[n][31:0], rb[n][31:0])}, rtag[n]);
      end
    end
    if (ev.vld) iss_cycles.push_back(cyc + 1);
  endtask

  task automatic new_req(input int n, input bit dbl);
    logic [63:0] a, b;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    if (dbl) begin
      a[62:52] = 11'(1015 + $urandom_range(0, 15));
      b[62:52] = 11'(1015 + $urandom_range(0, 15));
    end else begin
      a[30:23] = 8'(120 + $urandom_range(0, 15));
      b[30:23] = 8'(120 + $urandom_range(0, 15));
    end
    rv[n]   = 1'b1;
    rdbl[n] = dbl;
    ra[n]   = a;
    rb[n]   = b;
    rtag[n] = tagc[n];
    tagc[n] = tagc[n] + 1'b1;
  endtask

  task automatic set_req(input int n, input bit dbl, input logic [63:0] a, input logic [63:0] b,
                         input logic [TAGW-1:0] tag);
    rv[n] = 1'b1; rdbl[n] = dbl; ra[n] = a; rb[n] = b; rtag[n] = tag;
  endtask

  task automatic half();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic adv();
    @(posedge clk);
    cyc++;
    #1;
    for (int n = 0; n < 2; n++) begin
      if (acc[n]) rv[n] = 1'b0;
      if (auto_en && !rv[n] && $urandom_range(0, 99) < p_req)
        new_req(n, $urandom_range(0, 99) < p_dbl);
    end
    if (auto_en) hold = ($urandom_range(0, 99) < 10);
    acc = 2'b00;
  endtask

  task automatic cycle();
    half();
    adv();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int  t0;
    bit  seen;
    total = 0; bad = 0; cyc = 0; auto_en = 1'b0; p_req = 70; p_dbl = 30;
    rst = 1'b1; hold = 1'b0; rv = 2'b00; rdbl = 2'b00; acc = 2'b00;
    ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0;
    rtag[0] = '0; rtag[1] = '0; tagc[0] = '0; tagc[1] = '0;
    ev = '0; m_rr = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    half();
    check("reset_issue", o_issue, 0);
    check("reset_busy", o_busy, 0);
    check("reset_rsp", {rspv1, rspv0}, 2'b00);
    adv();

    // Pack two singles in one issue.
    set_req(0, 1'b0, 64'h0000_0000_3F80_0000, 64'h0000_0000_4000_0000, 2'd1);
    set_req(1, 1'b0, 64'h0000_0000_4040_0000, 64'h0000_0000_4080_0000, 2'd2);
    half();
    check("pack_ready", {rdy1, rdy0}, 2'b11);
    t0 = cyc;
    adv();
    half();
    check("pack_mode", o_mode, 0);
    check("pack_A", o_A, 64'h4040_0000_3F80_0000);
    check("pack_B", o_B, 64'h4080_0000_4000_0000);
    check("pack_lanes", o_lane_valid, 2'b11);
    seen = 1'b0;
    for (int k = 0; k < int'(LAT) + 4 && !seen; k++) begin
      adv();
      half();
      if (rspv0) begin
        seen = 1'b1;
        check("pack_r0_data", rspd0, 64'h0000_0000_4040_0000);
        check("pack_r0_tag", rspt0, 1);
        check("pack_r1_valid", rspv1, 1);
        check("pack_r1_data", rspd1, 64'h0000_0000_40E0_0000);
        check("pack_r1_tag", rspt1, 2);
        check("pack_latency", cyc - t0, LAT + 1);
      end
    end
    check("pack_rsp_seen", seen, 1);
    adv();

    // Two doubles with rr=0: r0 first, r1 next cycle.
    new_req(0, 1'b1);
    new_req(1, 1'b1);
    half();
    check("dd_ready", {rdy1, rdy0}, 2'b01);
    adv();
    half();
    check("dd_ready1", rdy1, 1);
    check("dd_mode", o_mode, 1);
    adv();
    repeat (LAT + 3) cycle();

    // Lone r0 single moves rr to r1, then r0 double vs r1 single.
    new_req(0, 1'b0);
    cycle();
    new_req(0, 1'b1);
    new_req(1, 1'b0);
    half();
    check("mix_ready", {rdy1, rdy0}, 2'b10);
    adv();
    half();
    check("mix_lanes", o_lane_valid, 2'b01);
    check("mix_A_hi", o_A[63:32], 0);
    check("mix_ready0", rdy0, 1);
    adv();
    half();
    check("mix_mode", o_mode, 1);
    adv();
    repeat (LAT + 3) cycle();

    // r0 streams 8 singles with wrapping tags.
    tagc[0] = '0;
    for (int i = 0; i < 8; i++) begin
      new_req(0, 1'b0);
      half();
      check("stream_ready", rdy0, 1);
      adv();
    end

    // Hold with both valid while the stream drains.
    hold = 1'b1;
    new_req(0, 1'b0);
    new_req(1, 1'b0);
    for (int k = 0; k < int'(LAT) + 2; k++) begin
      half();
      check("hold_ready", {rdy1, rdy0}, 2'b00);
      if (k == int'(LAT)) check("hold_busy_tail", o_busy, 1);
      if (k == int'(LAT) + 1) check("hold_busy_low", o_busy, 0);
      adv();
    end
    hold = 1'b0;
    repeat (LAT + 3) cycle();

    // Reset two cycles after three issues drops them all.
    for (int i = 0; i < 3; i++) cycle_req();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    half();
    check("rst_issue", o_issue, 0);
    check("rst_busy", o_busy, 0);
    check("rst_A", o_A, 0);
    check("rst_lanes", o_lane_valid, 2'b00);
    check("rst_rsp", {rspv1, rspv0}, 2'b00);
    adv();
    repeat (LAT + 3) cycle();

    // Random traffic.
    auto_en = 1'b1;
    repeat (1500) cycle();
    auto_en = 1'b0;
    hold    = 1'b0;
    repeat (LAT + 8) cycle();
    check("drain_empty", expq.size(), 0);
    check("drain_valid", rv, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic cycle_req();
    new_req(0, 1'b0);
    cycle();
  endtask

endmodule
